m_control_sequencer: RTL and testbench

- Controller-sequencer for the SAP-2 shared 8-bit bus.
- Steps a T-state counter through fetch and execute phases, decodes the opcode held in the instruction register, and drives the load and tri-state output-enable strobes of PC, MAR, RAM, IR, A, B, ALU and the output port.
- Sits between the IR and every bus-attached register, including the B register's inLoad/inEnableOut pins.
- Guarantees at most one bus driver per cycle.

---
 rtl/m_sap2_pkg.sv | 51 +++++
 rtl/m_control_sequencer_if.sv | 37 +++
 rtl/m_tstate_counter.sv | 33 +++
 rtl/m_control_sequencer.sv | 100 ++++++++++
 tb/tb_m_control_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_sap2_pkg.sv
// Shared definitions for the SAP-2 controller-sequencer: opcodes, T-state
// encodings and the control-word layout driven onto the bus registers.
package m_sap2_pkg;

  localparam int T_LAST  = 6;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } tstate_e;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_MVI_A  = 8'h3E;
  localparam logic [7:0] OP_MVI_B  = 8'h06;
  localparam logic [7:0] OP_MOV_AB = 8'h78;
  localparam logic [7:0] OP_MOV_BA = 8'h47;
  localparam logic [7:0] OP_ADD_B  = 8'h80;
  localparam logic [7:0] OP_SUB_B  = 8'h90;
  localparam logic [7:0] OP_OUT    = 8'hD3;
  localparam logic [7:0] OP_HLT    = 8'h76;

  typedef struct packed {
    logic pc_en_out;
    logic pc_inc;
    logic mar_load;
    logic ram_en_out;
    logic ir_load;
    logic a_load;
    logic a_en_out;
    logic b_load;
    logic b_en_out;
    logic alu_en_out;
    logic alu_sub;
    logic out_load;
  } ctrl_t;

  function automatic logic is_defined(input logic [7:0] op);
    case (op)
      OP_NOP, OP_MVI_A, OP_MVI_B, OP_MOV_AB, OP_MOV_BA,
      OP_ADD_B, OP_SUB_B, OP_OUT, OP_HLT: is_defined = 1'b1;
      default:                            is_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/m_control_sequencer_if.sv
// Bundle between the sequencer and the datapath: run/opcode inputs plus all
// load and output-enable strobes and status.
interface m_control_sequencer_if;
  import m_sap2_pkg::*;

  logic               inRun;
  logic [7:0]         inIR;
  logic               outPcEnableOut;
  logic               outPcInc;
  logic               outMarLoad;
  logic               outRamEnableOut;
  logic               outIrLoad;
  logic               outALoad;
  logic               outAEnableOut;
  logic               outBLoad;
  logic               outBEnableOut;
  logic               outAluEnableOut;
  logic               outAluSub;
  logic               outOutLoad;
  logic [STATE_W-1:0] outState;
  logic               outHalted;
  logic               outIllegal;

  modport master (
    input  inRun, inIR,
    output outPcEnableOut, outPcInc, outMarLoad, outRamEnableOut, outIrLoad,
           outALoad, outAEnableOut, outBLoad, outBEnableOut, outAluEnableOut,
           outAluSub, outOutLoad, outState, outHalted, outIllegal
  );

  modport slave (
    output inRun, inIR,
    input  outPcEnableOut, outPcInc, outMarLoad, outRamEnableOut, outIrLoad,
           outALoad, outAEnableOut, outBLoad, outBEnableOut, outAluEnableOut,
           outAluSub, outOutLoad, outState, outHalted, outIllegal
  );
endinterface

// File: rtl/m_tstate_counter.sv
// T-state register: advances T1..T6 while running, wraps to T1 on restart
// or after the last T-state, and parks in HALT until reset.
module m_tstate_counter
  import m_sap2_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_run,
  input  logic    i_restart,
  input  logic    i_go_halt,
  output tstate_e o_state
);

  tstate_e r_state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_T1;
    end else if (r_state == S_HALT) begin
      r_state <= S_HALT;
    end else if (i_run) begin
      if (i_go_halt)
        r_state <= S_HALT;
      else if (i_restart || int'(r_state) >= T_LAST)
        r_state <= S_T1;
      else
        r_state <= tstate_e'(r_state + 3'd1);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/m_control_sequencer.sv
// SAP-2 controller-sequencer: decodes (T-state, opcode) into bus strobes,
// gated by run and reset, and tracks the sticky illegal-opcode flag.
module m_control_sequencer
  import m_sap2_pkg::*;
(
  input  logic                   inCLK,
  input  logic                   inReset,
  m_control_sequencer_if.master  bus
);

  tstate_e w_state;
  ctrl_t   w_ctrl;
  ctrl_t   w_gated;
  logic    w_restart;
  logic    w_go_halt;
  logic    w_is_mvi;
  logic    r_illegal;

  m_tstate_counter u_tstate (
    .i_clk     (inCLK),
    .i_reset   (inReset),
    .i_run     (bus.inRun),
    .i_restart (w_restart),
    .i_go_halt (w_go_halt),
    .o_state   (w_state)
  );

  assign w_is_mvi = (bus.inIR == OP_MVI_A) || (bus.inIR == OP_MVI_B);

  always_comb begin
    w_ctrl    = '0;
    w_restart = 1'b0;
    w_go_halt = 1'b0;
    case (w_state)
      S_T1: begin w_ctrl.pc_en_out = 1'b1; w_ctrl.mar_load = 1'b1; end
      S_T2: w_ctrl.pc_inc = 1'b1;
      S_T3: begin w_ctrl.ram_en_out = 1'b1; w_ctrl.ir_load = 1'b1; end
      S_T4: begin
        w_restart = 1'b1;
        case (bus.inIR)
          OP_MVI_A, OP_MVI_B: begin
            w_ctrl.pc_en_out = 1'b1; w_ctrl.mar_load = 1'b1; w_restart = 1'b0;
          end
          OP_MOV_AB: begin w_ctrl.b_en_out = 1'b1; w_ctrl.a_load = 1'b1; end
          OP_MOV_BA: begin w_ctrl.a_en_out = 1'b1; w_ctrl.b_load = 1'b1; end
          OP_ADD_B:  begin w_ctrl.alu_en_out = 1'b1; w_ctrl.a_load = 1'b1; end
          OP_SUB_B: begin
            w_ctrl.alu_en_out = 1'b1; w_ctrl.a_load = 1'b1; w_ctrl.alu_sub = 1'b1;
          end
          OP_OUT:    begin w_ctrl.a_en_out = 1'b1; w_ctrl.out_load = 1'b1; end
          OP_HLT:    begin w_go_halt = 1'b1; w_restart = 1'b0; end
          default:   ;
        endcase
      end
      // A non-MVI opcode appearing in T5/T6 ends the instruction rather than
      // running stray fetch strobes.
      S_T5: begin
        if (w_is_mvi) w_ctrl.pc_inc = 1'b1;
        else          w_restart     = 1'b1;
      end
      S_T6: begin
        w_restart         = 1'b1;
        w_ctrl.ram_en_out = w_is_mvi;
        w_ctrl.a_load     = (bus.inIR == OP_MVI_A);
        w_ctrl.b_load     = (bus.inIR == OP_MVI_B);
      end
      default: ;
    endcase
  end

  assign w_gated = (bus.inRun && !inReset) ? w_ctrl : '0;

  always_ff @(posedge inCLK) begin
    if (inReset)
      r_illegal <= 1'b0;
    else if (bus.inRun && w_state == S_T4 && !is_defined(bus.inIR))
      r_illegal <= 1'b1;
  end

  assign bus.outPcEnableOut  = w_gated.pc_en_out;
  assign bus.outPcInc        = w_gated.pc_inc;
  assign bus.outMarLoad      = w_gated.mar_load;
  assign bus.outRamEnableOut = w_gated.ram_en_out;
  assign bus.outIrLoad       = w_gated.ir_load;
  assign bus.outALoad        = w_gated.a_load;
  assign bus.outAEnableOut   = w_gated.a_en_out;
  assign bus.outBLoad        = w_gated.b_load;
  assign bus.outBEnableOut   = w_gated.b_en_out;
  assign bus.outAluEnableOut = w_gated.alu_en_out;
  assign bus.outAluSub       = w_gated.alu_sub;
  assign bus.outOutLoad      = w_gated.out_load;
  assign bus.outState        = w_state;
  assign bus.outHalted       = (w_state == S_HALT);
  assign bus.outIllegal      = r_illegal;

  a_one_driver: assert property (@(posedge inCLK) disable iff (inReset)
    $onehot0({w_gated.pc_en_out, w_gated.ram_en_out, w_gated.a_en_out,
              w_gated.b_en_out, w_gated.alu_en_out}));

endmodule

// File: tb/tb_m_control_sequencer.sv
// Directed bench for m_control_sequencer: walks each instruction class cycle
// by cycle against hand-written state/strobe tables.
module tb_m_control_sequencer;

  logic inCLK;
  logic inReset;
  int   total = 0;
  int   bad   = 0;

  m_control_sequencer_if bus ();

  m_control_sequencer dut (
    .inCLK   (inCLK),
    .inReset (inReset),
    .bus     (bus.master)
  );

  initial inCLK = 1'b0;
  always #5 inCLK = ~inCLK;

  // Strobe vector order: PcE PcInc Mar RamE IrL AL AE BL BE AluE Sub OutL
  localparam logic [11:0] B_PCE = 12'h800, B_PCI = 12'h400, B_MAR = 12'h200;
  localparam logic [11:0] B_RAM = 12'h100, B_IRL = 12'h080, B_AL  = 12'h040;
  localparam logic [11:0] B_AE  = 12'h020, B_BL  = 12'h010, B_BE  = 12'h008;
  localparam logic [11:0] B_ALU = 12'h004, B_SUB = 12'h002, B_OUT = 12'h001;
  localparam logic [11:0] F1 = B_PCE | B_MAR, F2 = B_PCI, F3 = B_RAM | B_IRL;

  wire [11:0] w_strb = {bus.outPcEnableOut, bus.outPcInc, bus.outMarLoad,
                        bus.outRamEnableOut, bus.outIrLoad, bus.outALoad,
                        bus.outAEnableOut, bus.outBLoad, bus.outBEnableOut,
                        bus.outAluEnableOut, bus.outAluSub, bus.outOutLoad};

  always @(negedge inCLK) begin
    if (!inReset) begin
      total++;
      if ($countones({bus.outPcEnableOut, bus.outRamEnableOut, bus.outAEnableOut,
                      bus.outBEnableOut, bus.outAluEnableOut}) > 1) begin
        bad++;
        $display("FAIL one_driver t=%0t: strb=%h required at most one enable", $time, w_strb);
      end
    end
  end

  task automatic tick();
    @(posedge inCLK);
    #2;
  endtask

  task automatic test_reset();
    total++;
    if (bus.outState !== 3'd1 || w_strb !== 12'h000 || bus.outHalted !== 1'b0 ||
        bus.outIllegal !== 1'b0) begin
      bad++;
      $display("FAIL reset: state=%0d strb=%h halt=%b ill=%b required 1 000 0 0",
               bus.outState, w_strb, bus.outHalted, bus.outIllegal);
    end
  endtask

  task automatic test_nop();
    logic [2:0]  st [4];
    logic [11:0] sb [4];
    st = '{3'd1, 3'd2, 3'd3, 3'd4};
    sb = '{F1, F2, F3, 12'h000};
    bus.inIR = 8'h00;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.outState !== st[i] || w_strb !== sb[i]) begin
        bad++;
        $display("FAIL nop_c%0d: state=%0d strb=%h required %0d %h",
                 i, bus.outState, w_strb, st[i], sb[i]);
      end
      tick();
    end
    total++;
    if (bus.outState !== 3'd1 || bus.outIllegal !== 1'b0) begin
      bad++;
      $display("FAIL nop_end: state=%0d ill=%b required 1 0", bus.outState, bus.outIllegal);
    end
  endtask

  task automatic test_mvi_a();
    logic [2:0]  st [6];
    logic [11:0] sb [6];
    st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    sb = '{F1, F2, F3, B_PCE | B_MAR, B_PCI, B_RAM | B_AL};
    for (int i = 0; i < 6; i++) begin
      // HLT on the IR lines during fetch must not disturb anything.
      bus.inIR = (i < 3) ? 8'h76 : 8'h3E;
      #1;
      total++;
      if (bus.outState !== st[i] || w_strb !== sb[i]) begin
        bad++;
        $display("FAIL mvi_a_c%0d: state=%0d strb=%h required %0d %h",
                 i, bus.outState, w_strb, st[i], sb[i]);
      end
      tick();
    end
    total++;
    if (bus.outState !== 3'd1) begin
      bad++;
      $display("FAIL mvi_a_end: state=%0d required 1", bus.outState);
    end
  endtask

  task automatic test_one_cycle_exec(input logic [7:0] op, input logic [11:0] exp_t4);
    logic [2:0]  st [4];
    logic [11:0] sb [4];
    st = '{3'd1, 3'd2, 3'd3, 3'd4};
    sb = '{F1, F2, F3, exp_t4};
    bus.inIR = op;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.outState !== st[i] || w_strb !== sb[i]) begin
        bad++;
        $display("FAIL exec_%h_c%0d: state=%0d strb=%h required %0d %h",
                 op, i, bus.outState, w_strb, st[i], sb[i]);
      end
      tick();
    end
    total++;
    if (bus.outState !== 3'd1) begin
      bad++;
      $display("FAIL exec_%h_end: state=%0d required 1", op, bus.outState);
    end
  endtask

  task automatic test_run_gate();
    bus.inIR = 8'h06;
    repeat (4) tick();
    total++;
    if (bus.outState !== 3'd5 || w_strb !== B_PCI) begin
      bad++;
      $display("FAIL gate_t5: state=%0d strb=%h required 5 %h", bus.outState, w_strb, B_PCI);
    end
    bus.inRun = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.outState !== 3'd5 || w_strb !== 12'h000) begin
        bad++;
        $display("FAIL gate_hold%0d: state=%0d strb=%h required 5 000", i, bus.outState, w_strb);
      end
      if (i < 3) tick();
    end
    bus.inRun = 1'b1;
    #1;
    total++;
    if (bus.outState !== 3'd5 || w_strb !== B_PCI) begin
      bad++;
      $display("FAIL gate_resume: state=%0d strb=%h required 5 %h", bus.outState, w_strb, B_PCI);
    end
    tick();
    total++;
    if (bus.outState !== 3'd6 || w_strb !== (B_RAM | B_BL)) begin
      bad++;
      $display("FAIL gate_t6: state=%0d strb=%h required 6 %h", bus.outState, w_strb, B_RAM | B_BL);
    end
    tick();
    total++;
    if (bus.outState !== 3'd1) begin
      bad++;
      $display("FAIL gate_end: state=%0d required 1", bus.outState);
    end
  endtask

  task automatic test_halt();
    bus.inIR = 8'h76;
    repeat (3) tick();
    total++;
    if (bus.outState !== 3'd4 || w_strb !== 12'h000) begin
      bad++;
      $display("FAIL halt_t4: state=%0d strb=%h required 4 000", bus.outState, w_strb);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.inRun = (i % 2 == 0);
      #1;
      total++;
      if (bus.outState !== 3'd7 || bus.outHalted !== 1'b1 || w_strb !== 12'h000) begin
        bad++;
        $display("FAIL halt_c%0d: state=%0d halt=%b strb=%h required 7 1 000",
                 i, bus.outState, bus.outHalted, w_strb);
      end
    end
    inReset = 1'b1;
    tick();
    total++;
    if (bus.outState !== 3'd1 || bus.outHalted !== 1'b0 || w_strb !== 12'h000) begin
      bad++;
      $display("FAIL halt_reset: state=%0d halt=%b strb=%h required 1 0 000",
               bus.outState, bus.outHalted, w_strb);
    end
    inReset  = 1'b0;
    bus.inRun = 1'b1;
    bus.inIR = 8'h00;
    #1;
    total++;
    if (bus.outState !== 3'd1 || w_strb !== F1) begin
      bad++;
      $display("FAIL halt_restart: state=%0d strb=%h required 1 %h", bus.outState, w_strb, F1);
    end
  endtask

  task automatic test_illegal();
    bus.inIR = 8'hFF;
    repeat (3) tick();
    total++;
    if (bus.outState !== 3'd4 || w_strb !== 12'h000 || bus.outIllegal !== 1'b0) begin
      bad++;
      $display("FAIL ill_t4: state=%0d strb=%h ill=%b required 4 000 0",
               bus.outState, w_strb, bus.outIllegal);
    end
    tick();
    total++;
    if (bus.outState !== 3'd1 || bus.outIllegal !== 1'b1) begin
      bad++;
      $display("FAIL ill_set: state=%0d ill=%b required 1 1", bus.outState, bus.outIllegal);
    end
    bus.inIR = 8'h00;
    tick();
    total++;
    if (bus.outState !== 3'd2 || bus.outIllegal !== 1'b1) begin
      bad++;
      $display("FAIL ill_sticky: state=%0d ill=%b required 2 1", bus.outState, bus.outIllegal);
    end
    inReset = 1'b1;
    #1;
    total++;
    if (w_strb !== 12'h000) begin
      bad++;
      $display("FAIL ill_rst_gate: strb=%h required 000", w_strb);
    end
    tick();
    total++;
    if (bus.outState !== 3'd1 || bus.outIllegal !== 1'b0) begin
      bad++;
      $display("FAIL ill_clear: state=%0d ill=%b required 1 0", bus.outState, bus.outIllegal);
    end
    inReset = 1'b0;
    #1;
    total++;
    if (bus.outState !== 3'd1 || w_strb !== F1) begin
      bad++;
      $display("FAIL ill_refetch: state=%0d strb=%h required 1 %h", bus.outState, w_strb, F1);
    end
  endtask

  initial begin
    inReset   = 1'b1;
    bus.inRun = 1'b0;
    bus.inIR  = 8'h00;
    repeat (2) tick();
    test_reset();
    inReset   = 1'b0;
    bus.inRun = 1'b1;
    #1;
    test_nop();
    test_mvi_a();
    test_one_cycle_exec(8'h90, B_ALU | B_AL | B_SUB);
    test_one_cycle_exec(8'h80, B_ALU | B_AL);
    test_one_cycle_exec(8'h78, B_BE | B_AL);
    test_one_cycle_exec(8'h47, B_AE | B_BL);
    test_one_cycle_exec(8'hD3, B_AE | B_OUT);
    test_run_gate();
    test_halt();
    test_illegal();
    test_nop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
